// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM states, FIFO entry width.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // FIFO entry = data bits plus parity-error and frame-error flags
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received frames; head entry is held in a register, zero when empty.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             wr_en, rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // The head register is loaded with what will sit at the read pointer next cycle,
    // bypassing the memory when that slot is being written right now.
    always_comb begin
        rd_ptr_d = rd_ptr + (AW+1)'(rd_en);
        wr_ptr_d = wr_ptr + (AW+1)'(wr_en);
        if (rd_ptr_d == wr_ptr_d)
            head_d = '0;
        else if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_d[AW-1:0]))
            head_d = wr_data;
        else
            head_d = mem[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = head_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable frame format and an output FIFO.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around each nominal point.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int EW = entry_width(DATA_BITS);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic ODD_EXP = (PARITY_MODE == PARITY_ODD);

    logic sync0, sync1, rxs, samp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= rx_in;
            sync1 <= sync0;
        end
    end
    assign rxs = sync1;

`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_LAG = 1;
    logic [1:0] hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= '1;
        else     hist <= {hist[0], rxs};
    end
    // decided one cycle after nominal: rxs is nominal+1, hist[0] nominal, hist[1] nominal-1
    assign samp = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
    localparam int SAMPLE_LAG = 0;
    assign samp = rxs;
`endif

    localparam int START_PT = CLKS_PER_BIT/2 - 1 + SAMPLE_LAG;
    localparam int BIT_PT   = CLKS_PER_BIT - 1;

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, ferr_new;
    logic                 sample_now, frame_done;
    logic                 fifo_full, fifo_empty, pop, overrun_q;
    logic [EW-1:0]        head;

    assign sample_now = (state_q == START) ? (cnt_q == CW'(START_PT)) : (cnt_q == CW'(BIT_PT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        ferr_new   = ferr_q | ~samp;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: if (sample_now) begin
                cnt_d   = '0;
                bit_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                state_d = samp ? IDLE : DATA;
            end
            DATA: if (sample_now) begin
                cnt_d   = '0;
                shreg_d = {samp, shreg_q[DATA_BITS-1:1]};
                if (bit_q == BW'(DATA_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            PARITY: if (sample_now) begin
                cnt_d   = '0;
                perr_d  = ((^shreg_q) ^ samp) != ODD_EXP;
                state_d = STOP;
            end
            STOP: if (sample_now) begin
                cnt_d  = '0;
                ferr_d = ferr_new;
                if (bit_q == BW'(STOP_BITS - 1)) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = !fifo_empty && rx_ready;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (frame_done),
        .wr_data ({ferr_new, perr_q, shreg_q}),
        .full    (fifo_full),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= frame_done && fifo_full && !pop;
    end

    assign rx_data       = head[DATA_BITS-1:0];
    assign rx_parity_err = head[DATA_BITS];
    assign rx_frame_err  = head[DATA_BITS+1];
    assign rx_valid      = !fifo_empty;
    assign overrun       = overrun_q;
    assign busy          = (state_q != IDLE);

endmodule
